// File: rtl/tick_gen_pkg.sv
// Shared types and elaboration helpers for the tick generator.
package tick_gen_pkg;

   typedef enum logic {IDLE, RUN} tick_state_t;

   typedef logic [1:0] rate_sel_t;

   function automatic int half_count(input int clk_hz, input int rate_hz);
      return clk_hz / (2 * rate_hz);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/tick_gen_div.sv
// Divider core of tick_gen: half-period counter, or with TICK_GEN_FRAC_EN a phase
// accumulator, raising toggle on the cycle whose edge ends a half-period.
module tick_gen_div
   import tick_gen_pkg::*;
#(
`ifdef TICK_GEN_FRAC_EN
   parameter int CLK_HZ = 27_000_000,
`endif
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clear,
   input  logic         run,
`ifdef TICK_GEN_FRAC_EN
   input  logic [W-1:0] incr,
`else
   input  logic [W-1:0] half,
`endif
   output logic         toggle
);

`ifdef TICK_GEN_FRAC_EN
   logic [W-1:0] acc;
   logic [W-1:0] acc_sum;

   // Remainder carries over each wrap, so the long-term rate is exact.
   assign acc_sum = acc + incr;
   assign toggle  = run && (acc_sum >= W'(CLK_HZ));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         acc <= '0;
      else if (clear)
         acc <= '0;
      else if (run)
         acc <= toggle ? acc_sum - W'(CLK_HZ) : acc_sum;
   end
`else
   logic [W-1:0] cnt;

   assign toggle = run && (cnt == half - 1'b1);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (run)
         cnt <= toggle ? '0 : cnt + 1'b1;
   end
`endif

endmodule

// File: rtl/tick_gen.sv
// Slow tick generator: square wave plus rising-edge strobe at one of four rates.
// Define TICK_GEN_FRAC_EN for the fractional (phase accumulator) divider.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int CLK_HZ   = 27_000_000,
   parameter int RATE0_HZ = 10,
   parameter int RATE1_HZ = 5,
   parameter int RATE2_HZ = 2,
   parameter int RATE3_HZ = 1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       en,
   input  logic       restart,
   input  logic [1:0] rate_sel,
   output logic       tick_sq,
   output logic       tick_pulse,
   output logic       busy
);

   localparam int HALF0 = half_count(CLK_HZ, RATE0_HZ);
   localparam int HALF1 = half_count(CLK_HZ, RATE1_HZ);
   localparam int HALF2 = half_count(CLK_HZ, RATE2_HZ);
   localparam int HALF3 = half_count(CLK_HZ, RATE3_HZ);

`ifdef TICK_GEN_FRAC_EN
   localparam int RATE_MAX = max4(RATE0_HZ, RATE1_HZ, RATE2_HZ, RATE3_HZ);
   localparam int W = $clog2(CLK_HZ + 2 * RATE_MAX) + 1;
`else
   localparam int HALF_MAX = max4(HALF0, HALF1, HALF2, HALF3);
   localparam int W = $clog2(HALF_MAX);
`endif

   if (HALF0 < 2 || HALF1 < 2 || HALF2 < 2 || HALF3 < 2) begin : g_half_check
      $error("tick_gen: every half period must be at least two clocks");
   end

   tick_state_t  state;
   rate_sel_t    active;
   logic [W-1:0] step;
   logic         clear;
   logic         run;
   logic         toggle;

   // Per-rate divider operand for the currently latched rate.
   always_comb begin
      step = '0;
      case (active)
`ifdef TICK_GEN_FRAC_EN
         2'd0: step = W'(2 * RATE0_HZ);
         2'd1: step = W'(2 * RATE1_HZ);
         2'd2: step = W'(2 * RATE2_HZ);
         2'd3: step = W'(2 * RATE3_HZ);
`else
         2'd0: step = W'(HALF0);
         2'd1: step = W'(HALF1);
         2'd2: step = W'(HALF2);
         2'd3: step = W'(HALF3);
`endif
         default: step = '0;
      endcase
   end

   // Restart and leaving RUN both take priority over a terminal count.
   assign clear = (state == IDLE) || !en || restart;
   assign run   = (state == RUN) && en && !restart;

   tick_gen_div #(
`ifdef TICK_GEN_FRAC_EN
      .CLK_HZ (CLK_HZ),
`endif
      .W      (W)
   ) u_div (
      .clk    (clk),
      .nrst   (nrst),
      .clear  (clear),
      .run    (run),
`ifdef TICK_GEN_FRAC_EN
      .incr   (step),
`else
      .half   (step),
`endif
      .toggle (toggle)
   );

   // Rate is re-latched only at half-period boundaries so no runt half-period appears.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         active     <= '0;
         tick_sq    <= 1'b0;
         tick_pulse <= 1'b0;
         busy       <= 1'b0;
      end else begin
         tick_pulse <= 1'b0;
         case (state)
            IDLE: begin
               tick_sq <= 1'b0;
               if (en) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  active <= rate_sel;
               end
            end
            RUN: begin
               if (!en) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  tick_sq <= 1'b0;
               end else if (restart) begin
                  tick_sq <= 1'b0;
                  active  <= rate_sel;
               end else if (toggle) begin
                  tick_sq    <= ~tick_sq;
                  tick_pulse <= ~tick_sq;
                  active     <= rate_sel;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus random stimulus,
// compared each cycle against an event-time reference model.
module tb_tick_gen;

`ifdef TICK_GEN_FRAC_EN
   localparam int ClkHz       = 210;
   localparam int ExpFirst0   = 11;
   localparam int ExpFirst3   = 105;
   localparam int PulseWindow = 2100;
   localparam int ExpPulses   = 100;
`else
   localparam int ClkHz       = 200;
   localparam int ExpFirst0   = 10;
   localparam int ExpFirst3   = 100;
   localparam int PulseWindow = 200;
   localparam int ExpPulses   = 10;
`endif

   logic       clk = 1'b0;
   logic       nrst;
   logic       en;
   logic       restart;
   logic [1:0] rateSel;
   logic       tickSq;
   logic       tickPulse;
   logic       busy;

   int checks = 0;
   int fails = 0;
   int edgeNum = 0;
   int n;
   int halfStart;
   int pulses;
   int firstRise;
   logic prevSq;

   bit mRun;
   bit mSq;
   bit mPulse;
   int mRate;
   int mResidue;
   int mNextAt;
   int mLastBoundary;

   tick_gen #(
      .CLK_HZ   (ClkHz),
      .RATE0_HZ (10),
      .RATE1_HZ (5),
      .RATE2_HZ (2),
      .RATE3_HZ (1)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .en         (en),
      .restart    (restart),
      .rate_sel   (rateSel),
      .tick_sq    (tickSq),
      .tick_pulse (tickPulse),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic int rateOf(input int sel);
      case (sel)
         0: return 10;
         1: return 5;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   // Reference model: each half-period is scheduled as an absolute edge number.
   task automatic modelSchedule();
      int inc;
      int d;
      inc = 2 * rateOf(mRate);
`ifdef TICK_GEN_FRAC_EN
      d = (ClkHz - mResidue + inc - 1) / inc;
      mResidue = mResidue + d * inc - ClkHz;
`else
      d = ClkHz / inc;
`endif
      mNextAt = edgeNum + d;
      mLastBoundary = edgeNum;
   endtask

   task automatic modelStart();
      mRate = rateSel;
      mResidue = 0;
      modelSchedule();
   endtask

   task automatic modelReset();
      mRun = 0;
      mSq = 0;
      mPulse = 0;
      mRate = 0;
      mResidue = 0;
      mNextAt = 0;
      mLastBoundary = 0;
   endtask

   task automatic modelEdge();
      if (!nrst) begin
         modelReset();
         return;
      end
      if (!mRun) begin
         mSq = 0;
         mPulse = 0;
         if (en) begin
            mRun = 1;
            modelStart();
         end
      end else if (!en) begin
         mRun = 0;
         mSq = 0;
         mPulse = 0;
      end else if (restart) begin
         mSq = 0;
         mPulse = 0;
         modelStart();
      end else if (edgeNum == mNextAt) begin
         mSq = !mSq;
         mPulse = mSq;
         mRate = rateSel;
         modelSchedule();
      end else begin
         mPulse = 0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edgeNum, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit e, input bit r, input logic [1:0] s);
      en = e;
      restart = r;
      rateSel = s;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      edgeNum++;
      modelEdge();
      #1;
      checkOutput("tick_sq", tickSq, mSq);
      checkOutput("tick_pulse", tickPulse, mPulse);
      checkOutput("busy", busy, mRun);
   endtask

   task automatic countToRise(input string tag, input int expected);
      int k;
      k = 0;
      do begin
         stepCycle();
         k++;
      end while (!tickPulse && k < 1000);
      checkOutput(tag, k, expected);
   endtask

   initial begin
      nrst = 1'b0;
      applyStimulus(1, 0, 0);
      modelReset();
      #12;
      checkOutput("reset tick_sq", tickSq, 0);
      checkOutput("reset tick_pulse", tickPulse, 0);
      checkOutput("reset busy", busy, 0);
      stepCycle();
      nrst = 1'b1;

      // First rise and pulse count from RUN entry at rate 0.
      stepCycle();
      pulses = 0;
      firstRise = -1;
      for (int i = 1; i <= PulseWindow; i++) begin
         stepCycle();
         if (tickPulse) begin
            pulses++;
            if (firstRise < 0) firstRise = i;
         end
      end
      checkOutput("first rise rate0", firstRise, ExpFirst0);
      checkOutput("pulse count", pulses, ExpPulses);

`ifndef TICK_GEN_FRAC_EN
      // Rate change five cycles into a half-period applies only at the boundary.
      n = 0;
      while ((edgeNum - mLastBoundary) != 5 && n < 100) begin
         stepCycle();
         n++;
      end
      checkOutput("reach mid half", n < 100, 1);
      applyStimulus(1, 0, 1);
      halfStart = mLastBoundary;
      prevSq = tickSq;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin
            stepCycle();
            n++;
         end while (tickSq == prevSq && n < 300);
         prevSq = tickSq;
         checkOutput(k == 0 ? "half before rate change" : "half after rate change",
                     edgeNum - halfStart, k == 0 ? 10 : 20);
         halfStart = edgeNum;
      end
`endif

      // Drop en while high, four edges into the half-period.
      n = 0;
      while (!(mSq && (edgeNum - mLastBoundary) == 4) && n < 400) begin
         stepCycle();
         n++;
      end
      checkOutput("reach high cnt4", n < 400, 1);
      applyStimulus(0, 0, 1);
      stepCycle();
      checkOutput("en drop tick_sq", tickSq, 0);
      checkOutput("en drop busy", busy, 0);
      checkOutput("en drop pulse", tickPulse, 0);
      applyStimulus(1, 0, 0);
      stepCycle();
      countToRise("rise after re-enable", ExpFirst0);

      // Restart on the terminal-count edge of a low half-period.
      n = 0;
      while (!(!mSq && mRun && mNextAt == edgeNum + 1) && n < 400) begin
         stepCycle();
         n++;
      end
      checkOutput("reach low terminal", n < 400, 1);
      applyStimulus(1, 1, 0);
      stepCycle();
      applyStimulus(1, 0, 0);
      checkOutput("restart tick_sq", tickSq, 0);
      checkOutput("restart pulse", tickPulse, 0);
      countToRise("rise after restart", ExpFirst0);

      // Asynchronous reset mid-period, then release at the slowest rate.
      repeat (7) stepCycle();
      #2;
      nrst = 1'b0;
      #1;
      modelReset();
      checkOutput("async reset tick_sq", tickSq, 0);
      checkOutput("async reset pulse", tickPulse, 0);
      checkOutput("async reset busy", busy, 0);
      applyStimulus(1, 0, 3);
      repeat (2) stepCycle();
      nrst = 1'b1;
      stepCycle();
      countToRise("first rise rate3", ExpFirst3);

      // Random en/restart/rate_sel traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 149) == 0,
                       2'($urandom_range(0, 3)));
         stepCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
